// File: rtl/ws_pkg.sv
// Shared types and constants for the weight-stationary psum collector.
// Optional feature macro used by the collector: WS_PSUM_RELU_EN.
package ws_pkg;

    localparam int unsigned PSUM_W   = 16;
    localparam int unsigned COLS_DEF = 4;

    typedef logic [PSUM_W-1:0]          psum_t;
    typedef psum_t [COLS_DEF-1:0]       psum_row_t;

endpackage

// File: rtl/ws_delay_line.sv
// Fixed-length register delay line; STAGES=0 degenerates to a wire.
module ws_delay_line #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned W      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] data,
    output logic [W-1:0] delayed
);

    generate
        if (STAGES == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, clear};
            assign delayed     = data;
        end else begin : g_pipe
            logic [W-1:0] stage_q [STAGES];

            // Shift register; clear flushes in-flight entries.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= data;
                    for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign delayed = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ws_psum_collector.sv
// Collects skewed bottom-row psums, aligns them into rows and buffers them
// in a FIFO drained over valid/ready.
// Optional: define WS_PSUM_RELU_EN to clamp negative fields to zero
// (adds one pipeline stage after alignment).
module ws_psum_collector
    import ws_pkg::*;
#(
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned DW    = PSUM_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [COLS*DW-1:0] in_psum,
    input  logic               in_valid,
    output logic [COLS*DW-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        row_count,
    output logic               overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [COLS*DW-1:0] aligned_row;
    logic               aligned_valid;
    logic [COLS*DW-1:0] wr_row;
    logic               wr_valid;

    // Column c is delayed COLS-1-c cycles so all columns line up with the last.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        ws_delay_line #(.STAGES(COLS - 1 - c), .W(DW)) u_col (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .data    (in_psum[c*DW +: DW]),
            .delayed (aligned_row[c*DW +: DW])
        );
    end

    ws_delay_line #(.STAGES(COLS - 1), .W(1)) u_valid (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .data    (in_valid),
        .delayed (aligned_valid)
    );

`ifdef WS_PSUM_RELU_EN
    logic [COLS*DW-1:0] relu_row_c;

    // Zero every field whose sign bit is set.
    always_comb begin
        relu_row_c = aligned_row;
        for (int c = 0; c < COLS; c++) begin
            if (aligned_row[c*DW + DW - 1]) relu_row_c[c*DW +: DW] = '0;
        end
    end

    // Extra stage between alignment and FIFO write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_row   <= '0;
            wr_valid <= 1'b0;
        end else if (clear) begin
            wr_row   <= '0;
            wr_valid <= 1'b0;
        end else begin
            wr_row   <= relu_row_c;
            wr_valid <= aligned_valid;
        end
    end
`else
    assign wr_row   = aligned_row;
    assign wr_valid = aligned_valid;
`endif

    logic [COLS*DW-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_ptr_n;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_n;
    logic               full;
    logic               do_wr;
    logic               do_rd;
    logic               drop;
    logic [COLS*DW-1:0] head_n;

    // FIFO next-state: a full write survives only if a read frees the slot.
    always_comb begin
        do_rd    = out_valid && out_ready;
        full     = (count == CW'(DEPTH));
        do_wr    = wr_valid && (!full || do_rd);
        drop     = wr_valid && full && !do_rd;
        rd_ptr_n = do_rd ? rd_ptr + AW'(1) : rd_ptr;
        count_n  = count + CW'(do_wr) - CW'(do_rd);
        if (count_n == '0)
            head_n = '0;
        else if (do_wr && (rd_ptr_n == wr_ptr))
            head_n = wr_row;
        else
            head_n = mem[rd_ptr_n];
    end

    // Row storage; no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr && !clear) mem[wr_ptr] <= wr_row;
    end

    // Pointers, occupancy, registered head and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            out_data  <= head_n;
            row_count <= row_count + 16'(do_rd);
            overflow  <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_ws_psum_collector.sv
// Scoreboard bench for ws_psum_collector (COLS=4, DW=16, DEPTH=8).
module tb_ws_psum_collector;

    localparam int unsigned COLS  = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
`ifdef WS_PSUM_RELU_EN
    localparam int unsigned LAT = COLS + 1;
`else
    localparam int unsigned LAT = COLS;
`endif

    typedef logic [COLS*DW-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    row_t        in_psum = '0;
    logic        in_valid = 1'b0;
    row_t        out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] row_count;
    logic        overflow;

    ws_psum_collector #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_psum   (in_psum),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_count (row_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    row_t sb [$];
    row_t hist [COLS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic row_t model(input row_t r);
        row_t m = r;
`ifdef WS_PSUM_RELU_EN
        for (int c = 0; c < COLS; c++) if (r[c*DW + DW - 1]) m[c*DW +: DW] = '0;
`endif
        return m;
    endfunction

    function automatic row_t rnd();
        return row_t'({$urandom(), $urandom()});
    endfunction

    function automatic row_t mkrow(input int k);
        row_t r;
        for (int c = 0; c < COLS; c++) r[c*DW +: DW] = DW'(k * 16 + c);
        return r;
    endfunction

    // One cycle: drive skewed columns after posedge, return at negedge.
    task automatic step(input logic v, input row_t r, input logic rdy,
                        input logic push, input logic clr);
        @(posedge clk);
        #1;
        for (int c = COLS - 1; c > 0; c--) hist[c] = hist[c-1];
        hist[0] = r;
        for (int c = 0; c < COLS; c++) in_psum[c*DW +: DW] = hist[c][c*DW +: DW];
        in_valid  = v;
        out_ready = rdy;
        clear     = clr;
        if (clr) sb.delete();
        if (push) sb.push_back(model(r));
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, rnd(), rdy, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, rnd(), 1'b0, 1'b0, 1'b1);
    endtask

    // Output monitor: pop on every accepted row, check hold under stall.
    logic stall_q = 1'b0;
    row_t stall_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (stall_q && out_valid) chk("hold", out_data, stall_data);
            if (!out_valid) chk("empty_data", out_data, 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious", 64'(out_valid), 64'd0);
                else                chk("data", out_data, sb.pop_front());
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        int nv, nr, first, last;
        row_t rr, exp_rr;
        for (int c = 0; c < COLS; c++) hist[c] = '0;

        // Reset state
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_rowcnt", 64'(row_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        #10 rst = 1'b1;

        // Skew alignment: single row {4,3,2,1}
        rr = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        for (int k = 0; k < 7; k++) begin
            if (k == 0) step(1'b1, rr, 1'b1, 1'b1, 1'b0);
            else        idle(1'b1);
            chk("skew_valid", 64'(out_valid), 64'(k == int'(LAT)));
            if (k == int'(LAT)) chk("skew_data", out_data, rr);
        end
        chk("skew_rowcnt", 64'(row_count), 64'd1);

        do_clear();
        idle(1'b0);
        chk("clr_rowcnt", 64'(row_count), 64'd0);

        // Streaming 8 back-to-back rows
        nv = 0; first = -1; last = -1;
        for (int k = 0; k < 20; k++) begin
            if (k < 8) step(1'b1, mkrow(k), 1'b1, 1'b1, 1'b0);
            else       idle(1'b1);
            if (out_valid) begin
                nv++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("stream_cnt", 64'(nv), 64'd8);
        chk("stream_run", 64'(last - first + 1), 64'd8);
        chk("stream_lat", 64'(first), 64'(LAT));
        chk("stream_ovf", 64'(overflow), 64'd0);
        chk("stream_rowcnt", 64'(row_count), 64'd8);

        // Backpressure: 9 rows into 8-deep FIFO, last one dropped
        do_clear();
        for (int k = 0; k < 9; k++) step(1'b1, mkrow(32 + k), 1'b0, k < 8, 1'b0);
        for (int k = 0; k < int'(LAT) + 1; k++) idle(1'b0);
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_valid", 64'(out_valid), 64'd1);
        nr = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1'b1);
            if (out_valid) nr++;
        end
        chk("bp_drained", 64'(nr), 64'd8);
        chk("bp_sb_left", 64'(sb.size()), 64'd0);
        chk("bp_rowcnt", 64'(row_count), 64'd8);
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with write and read on the same edge
        do_clear();
        for (int k = 0; k < 8; k++) step(1'b1, mkrow(64 + k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < int'(LAT); k++) idle(1'b0);
        step(1'b1, mkrow(80), 1'b0, 1'b1, 1'b0);
        for (int j = 1; j < int'(LAT); j++) idle(j == int'(LAT) - 1);
        idle(1'b0);
        idle(1'b0);
        chk("fullrw_ovf", 64'(overflow), 64'd0);
        nr = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1'b1);
            if (out_valid) nr++;
        end
        chk("fullrw_drained", 64'(nr), 64'd8);
        chk("fullrw_rowcnt", 64'(row_count), 64'd9);
        chk("fullrw_sb_left", 64'(sb.size()), 64'd0);

        // Clear with 3 rows buffered and one in the skew pipe
        do_clear();
        for (int k = 0; k < 3; k++) step(1'b1, mkrow(96 + k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < int'(LAT); k++) idle(1'b0);
        step(1'b1, mkrow(100), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        do_clear();
        idle(1'b1);
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_rowcnt2", 64'(row_count), 64'd0);
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            if (out_valid) nv++;
        end
        chk("clr_no_emit", 64'(nv), 64'd0);

        // Signed pattern (clamped when the ReLU stage is built in)
        rr = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0005};
`ifdef WS_PSUM_RELU_EN
        exp_rr = {16'h0000, 16'h0000, 16'h7FFF, 16'h0005};
`else
        exp_rr = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0005};
`endif
        for (int k = 0; k <= int'(LAT) + 1; k++) begin
            if (k == 0) step(1'b1, rr, 1'b1, 1'b1, 1'b0);
            else        idle(1'b1);
            chk("sign_valid", 64'(out_valid), 64'(k == int'(LAT)));
            if (k == int'(LAT)) chk("sign_data", out_data, exp_rr);
        end

        // Random traffic and random backpressure, never oversubscribed
        do_clear();
        for (int k = 0; k < 60; k++) begin
            logic v;
            v = ($urandom_range(0, 1) == 1) && (sb.size() < int'(DEPTH));
            step(v, rnd(), 1'($urandom_range(0, 1)), v, 1'b0);
        end
        for (int k = 0; k < 30 && sb.size() > 0; k++) idle(1'b1);
        chk("rand_sb_left", 64'(sb.size()), 64'd0);
        chk("rand_ovf", 64'(overflow), 64'd0);

        // Asynchronous reset mid-drain
        for (int k = 0; k < 2; k++) step(1'b1, mkrow(120 + k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < int'(LAT); k++) idle(1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", out_data, 64'd0);
        sb.delete();
        #3 rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            if (out_valid) nv++;
        end
        chk("arst_no_emit", 64'(nv), 64'd0);
        chk("arst_rowcnt", 64'(row_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws_psum_collector.md
Name: ws_psum_collector

Overview:
- Downstream stage of the weight-stationary systolic array.
- Captures the bottom-row PE partial sums (out_psum of each column's last PE). These arrive skewed by one cycle per column.
- De-skews them into one aligned row vector and buffers rows in a small FIFO.
- Drains rows to the output buffer over a valid/ready handshake.

Parameters:
- COLS, 4, number of PE columns; column c output lags column 0 by c cycles.
- DW, 16, psum width (matches PE psum width).
- DEPTH, 8, FIFO depth in rows; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of skew pipe, FIFO, counters and flag.
- in_psum  in  COLS*DW  bottom-row psums; column c at bits [c*DW +: DW].
- in_valid  in  1  column 0 psum valid this cycle; column c data is valid c cycles later.
- out_data  out  COLS*DW  head FIFO row, column-aligned.
- out_valid  out  1  head row available.
- out_ready  in  1  consumer accepts head row when out_valid && out_ready.
- row_count  out  16  rows accepted by the consumer since reset/clear; wraps at 2^16.
- overflow  out  1  sticky: an aligned row was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async): all skew registers, FIFO pointers/count, row_count and overflow clear to 0. out_valid=0 and out_data=0 immediately.
- De-skew:
  - Column c passes through COLS-1-c registers; column COLS-1 is unregistered.
  - in_valid passes through a COLS-1 stage valid pipe.
  - Aligned vector and aligned valid are present in cycle t+COLS-1 for in_valid at cycle t.
- FIFO write:
  - On the clock edge ending cycle t+COLS-1 when aligned valid=1.
  - out_valid is first high in cycle t+COLS (COLS=4: in_valid cycle 0 -> out_valid cycle 4).
- Read: on an edge with out_valid && out_ready; head advances; row_count increments.
- out_data: equals head entry when out_valid=1; 0 when the FIFO is empty. It must not change while out_valid=1 and out_ready=0.
- Full:
  - Aligned write with count==DEPTH and no simultaneous read: row dropped, overflow set (sticky until rst/clear).
  - Write and read in the same cycle while full: both happen, no drop.
- Empty: a simultaneous write and read is impossible because out_valid=0. The write lands and out_valid rises next cycle (no bypass).
- Back-to-back: in_valid on consecutive cycles yields one FIFO row per cycle. Throughput is 1 row/cycle when out_ready=1.
- Pointers: wrap modulo DEPTH. count ranges 0..DEPTH.
- clear=1 at an edge:
  - Empties the FIFO, zeroes the skew valid pipe (in-flight partial rows are discarded), row_count=0, overflow=0.
  - clear has priority over a simultaneous write/read.
- Reset mid-drain: everything is lost; no partial row is emitted after rst deasserts.
- Arithmetic: no arithmetic on data; psums are stored bit-exact, except when the optional feature below is enabled.

Optional Feature:
- Macro WS_PSUM_RELU_EN.
- Defined: each DW-bit field of the aligned row is treated as signed two's complement. Negative fields are written to the FIFO as 0. One extra pipeline register follows alignment, so latency becomes COLS+1 cycles.
- Undefined: values pass through unmodified with latency COLS.
- Overflow and full handling are identical in both cases.

Decomposition:
- Package ws_pkg:
  - PSUM_W=16 and a default COLS constant.
  - typedef psum_t (logic [PSUM_W-1:0]).
  - typedef psum_row_t (array of COLS psum_t).
- Sub-module ws_delay_line: parameter STAGES (0 allowed = wire) and width W. One instance per column plus one for the valid pipe.
- The FIFO stays inline.

Test Plan:
- Skew alignment:
  - Stimulus (COLS=4): in_valid at cycle 0; col0=0x0001 at cycle 0, col1=0x0002 at cycle 1, col2=0x0003 at cycle 2, col3=0x0004 at cycle 3; out_ready=1.
  - Required: out_valid only in cycle 4, out_data={0x0004,0x0003,0x0002,0x0001}, row_count=1.
- Streaming: 8 consecutive in_valid rows (col c = row*16+c), out_ready=1 -> 8 consecutive out_valid cycles in order, overflow=0, row_count=8.
- Backpressure and full:
  - out_ready=0, 9 rows pushed -> first 8 retained, overflow=1.
  - Then out_ready=1 -> exactly 8 rows drain in order.
- Full with simultaneous read: FIFO at 8 rows, a write coincides with a read -> no drop, overflow stays 0, count stays 8.
- Clear and reset:
  - clear asserted with 3 rows buffered and one row in the skew pipe -> out_valid=0 next cycle, row_count=0, no later emission.
  - rst pulled low mid-cycle -> out_valid and out_data go 0 without waiting for a clock edge.
- WS_PSUM_RELU_EN: row {0xFFFF,0x8000,0x7FFF,0x0005} -> out_data {0,0,0x7FFF,0x0005} at cycle COLS+1. Without the macro, the row is unchanged at cycle COLS.
